uart_rx_frame_checker: RTL and testbench
========================================

Name: uart_rx_frame_checker

Overview:
Parametrised successor to the UART RX single-bit parity checker. Accepts the sampler's per-bit strobes and runs a per-frame FSM: START -> DATA -> optional PARITY -> STOP. Serially assembles DATA_W data bits and accumulates parity on the fly. Checks start, parity and stop bits, then presents the frame with per-frame error flags and saturating error counters to the RX top level.

Parameters:
DATA_W, 8, data bits per frame; legal 5..9; LSB received first.
CNT_W, 8, width of each saturating error counter; legal 1..16.

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
frame_start  in  1  1-cycle pulse from the start-edge detector; honoured only in IDLE
bit_vld  in  1  1-cycle strobe; sampled_bit is valid this cycle
sampled_bit  in  1  majority-sampled line value
par_en  in  1  1 = frame carries a parity bit
par_typ  in  2  00 even, 01 odd, 10 mark (always 1), 11 space (always 0)
cnt_clr  in  1  synchronous clear of all error counters
busy  out  1  high whenever FSM is not IDLE
p_data  out  DATA_W  assembled data; updated only with data_vld
data_vld  out  1  1-cycle pulse, frame complete
par_err  out  1  parity mismatch for this frame; valid with data_vld
stp_err  out  1  stop bit sampled 0; valid with data_vld
strt_err  out  1  1-cycle pulse, start bit sampled 1 (glitch)
par_err_cnt  out  CNT_W  saturating count of par_err frames
stp_err_cnt  out  CNT_W  saturating count of stp_err frames
strt_err_cnt  out  CNT_W  saturating count of strt_err events

Behaviour:
- Reset: all outputs, counters, shift register, parity accumulator and bit counter = 0; FSM = IDLE. Takes effect immediately, including mid-frame. The partial frame is discarded and no data_vld is issued.
- States: IDLE, START, DATA, PARITY, STOP. All outputs are registered.
- IDLE: on frame_start, latch par_en and par_typ into frame config, clear the accumulator and bit counter, go to START. Config changes mid-frame have no effect until the next frame_start.
- START, on bit_vld:
  - sampled_bit = 0: go to DATA.
  - sampled_bit = 1: pulse strt_err next cycle, increment strt_err_cnt, return to IDLE.
- DATA, each bit_vld:
  - shift sampled_bit into shift register at position bit count (LSB first);
  - acc <= acc ^ sampled_bit;
  - increment bit counter.
  - After the DATA_W-th bit: go to PARITY if latched par_en = 1, else STOP.
- PARITY, on bit_vld:
  - expected = acc (even), ~acc (odd), 1 (mark), 0 (space);
  - store perr = (sampled_bit != expected);
  - go to STOP.
  - perr = 0 when parity is disabled.
- STOP, on bit_vld: cycle after the strobe:
  - data_vld = 1;
  - p_data = shift register;
  - par_err = perr;
  - stp_err = ~sampled_bit;
  - increment the corresponding counters;
  - return to IDLE.
  - Latency: one clk from the stop-bit bit_vld to data_vld.
- par_err and stp_err hold their values until the next data_vld; p_data holds likewise.
- frame_start while busy: ignored. bit_vld in IDLE: ignored. Cycles without bit_vld: state holds.
- Counters:
  - saturate at 2^CNT_W-1; no wrap;
  - cnt_clr has priority over a simultaneous increment (result 0);
  - both par_err and stp_err set on one frame increments both counters.
- Back-to-back: frame_start is accepted in the same cycle data_vld is high, since FSM is IDLE then.

Test Plan:
- DATA_W=8, par_en=1, even, data 0xA5 LSB-first, parity bit 0, stop 1 -> data_vld 1 cycle after stop strobe, p_data=0xA5, par_err=0, stp_err=0, all counters 0.
- Same frame with par_typ=odd -> par_err=1, par_err_cnt=1; repeat with mark, parity bit 1 -> par_err=0; space, parity bit 1 -> par_err=1, count=2.
- par_en=0, data 0x3C, stop bit 0 -> p_data=0x3C, par_err=0, stp_err=1, stp_err_cnt=1; the bit after data is treated as the stop bit.
- frame_start then start bit sampled 1 -> strt_err pulse, strt_err_cnt=1, busy=0, no data_vld; next valid frame is received correctly.
- CNT_W=2: five parity-error frames -> par_err_cnt stops at 3. cnt_clr asserted in the same cycle as a 6th error's data_vld -> counter reads 0.
- Mid-frame after 4 data bits:
  - drive rst low -> busy=0, all outputs 0 immediately;
  - toggle par_typ mid-frame in a separate run -> parity checked against the type latched at frame_start.
- DATA_W=5 and DATA_W=9 builds: frames 0x15 and 0x1FF, even parity -> correct p_data, par_err=0.

Source files
------------

// File: rtl/uart_rx_frame_checker.sv
// rtl/uart_rx_frame_checker.sv - UART RX per-frame checker: start/data/parity/stop with error flags and counters
module uart_rx_frame_checker #(
   parameter int DATA_W = 8,
   parameter int CNT_W  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              frame_start,
   input  logic              bit_vld,
   input  logic              sampled_bit,
   input  logic              par_en,
   input  logic [1:0]        par_typ,
   input  logic              cnt_clr,
   output logic              busy,
   output logic [DATA_W-1:0] p_data,
   output logic              data_vld,
   output logic              par_err,
   output logic              stp_err,
   output logic              strt_err,
   output logic [CNT_W-1:0]  par_err_cnt,
   output logic [CNT_W-1:0]  stp_err_cnt,
   output logic [CNT_W-1:0]  strt_err_cnt
);

   localparam int BC_W = $clog2(DATA_W + 1);
   localparam logic [BC_W-1:0] LAST_BIT = BC_W'(DATA_W - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic              cfg_par_en;
   logic [1:0]        cfg_par_typ;
   logic [DATA_W-1:0] shift_reg;
   logic [BC_W-1:0]   bit_cnt;
   logic              acc;
   logic              perr;
   logic              exp_par;
   logic              frame_done;
   logic              start_bad;

   // saturating increment; a clear wins over a simultaneous increment
   function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] c,
                                                  input logic inc, input logic clr);
      if (clr)
         return '0;
      if (inc && (c != '1))
         return c + CNT_W'(1);
      return c;
   endfunction

   // state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         state <= S_IDLE;
      else
         state <= state_nxt;
   end

   // next-state decode plus single-cycle frame-complete / start-glitch events
   always_comb begin
      state_nxt  = state;
      frame_done = 1'b0;
      start_bad  = 1'b0;
      case (state)
         S_IDLE:
            if (frame_start)
               state_nxt = S_START;
         S_START:
            if (bit_vld) begin
               if (sampled_bit) begin
                  start_bad = 1'b1;
                  state_nxt = S_IDLE;
               end else begin
                  state_nxt = S_DATA;
               end
            end
         S_DATA:
            if (bit_vld && (bit_cnt == LAST_BIT))
               state_nxt = cfg_par_en ? S_PARITY : S_STOP;
         S_PARITY:
            if (bit_vld)
               state_nxt = S_STOP;
         S_STOP:
            if (bit_vld) begin
               frame_done = 1'b1;
               state_nxt  = S_IDLE;
            end
         default:
            state_nxt = S_IDLE;
      endcase
   end

   // expected parity bit for the type latched at frame_start
   always_comb begin
      exp_par = 1'b0;
      case (cfg_par_typ)
         2'b00:   exp_par = acc;
         2'b01:   exp_par = ~acc;
         2'b10:   exp_par = 1'b1;
         default: exp_par = 1'b0;
      endcase
   end

   // frame config latch, LSB-first data assembly, running parity and parity check
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cfg_par_en  <= 1'b0;
         cfg_par_typ <= 2'b00;
         shift_reg   <= '0;
         bit_cnt     <= '0;
         acc         <= 1'b0;
         perr        <= 1'b0;
      end else begin
         case (state)
            S_IDLE:
               if (frame_start) begin
                  cfg_par_en  <= par_en;
                  cfg_par_typ <= par_typ;
                  bit_cnt     <= '0;
                  acc         <= 1'b0;
                  perr        <= 1'b0;
               end
            S_DATA:
               if (bit_vld) begin
                  // shifting in from the top leaves the first bit at bit 0 after DATA_W bits
                  shift_reg <= {sampled_bit, shift_reg[DATA_W-1:1]};
                  acc       <= acc ^ sampled_bit;
                  bit_cnt   <= bit_cnt + BC_W'(1);
               end
            S_PARITY:
               if (bit_vld)
                  perr <= (sampled_bit != exp_par);
            default: ;
         endcase
      end
   end

   // registered frame outputs; flags and data hold until the next frame completes
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         busy     <= 1'b0;
         p_data   <= '0;
         data_vld <= 1'b0;
         par_err  <= 1'b0;
         stp_err  <= 1'b0;
         strt_err <= 1'b0;
      end else begin
         busy     <= (state_nxt != S_IDLE);
         data_vld <= frame_done;
         strt_err <= start_bad;
         if (frame_done) begin
            p_data  <= shift_reg;
            par_err <= perr;
            stp_err <= ~sampled_bit;
         end
      end
   end

   // saturating error counters
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         par_err_cnt  <= '0;
         stp_err_cnt  <= '0;
         strt_err_cnt <= '0;
      end else begin
         par_err_cnt  <= cnt_next(par_err_cnt, frame_done & perr, cnt_clr);
         stp_err_cnt  <= cnt_next(stp_err_cnt, frame_done & ~sampled_bit, cnt_clr);
         strt_err_cnt <= cnt_next(strt_err_cnt, start_bad, cnt_clr);
      end
   end

endmodule

// File: tb/tb_uart_rx_frame_checker.sv
// tb/tb_uart_rx_frame_checker.sv - self-checking bench for uart_rx_frame_checker
module tb_uart_rx_frame_checker;

   logic clk;
   logic rst;

   logic       fs [3];
   logic       bv [3];
   logic       sb [3];
   logic       pe [3];
   logic       cc [3];
   logic [1:0] pt [3];

   logic busy_o [3];
   logic dv     [3];
   logic perr_o [3];
   logic serr_o [3];
   logic terr_o [3];

   logic [7:0] pd8;
   logic [4:0] pd5;
   logic [8:0] pd9;
   logic [1:0] pc0, sc0, tc0;
   logic [7:0] pc1, sc1, tc1;
   logic [7:0] pc2, sc2, tc2;

   int checks;
   int errors;

   int         cnt_max [3] = '{3, 255, 255};
   int         width   [3] = '{8, 5, 9};
   int         exp_pc  [3];
   int         exp_sc  [3];
   int         exp_tc  [3];
   logic [8:0] exp_pd  [3];
   logic       exp_pe  [3];
   logic       exp_se  [3];
   bit         pre_started;

   uart_rx_frame_checker #(.DATA_W(8), .CNT_W(2)) u_d8 (
      .clk(clk), .rst(rst), .frame_start(fs[0]), .bit_vld(bv[0]), .sampled_bit(sb[0]),
      .par_en(pe[0]), .par_typ(pt[0]), .cnt_clr(cc[0]), .busy(busy_o[0]), .p_data(pd8),
      .data_vld(dv[0]), .par_err(perr_o[0]), .stp_err(serr_o[0]), .strt_err(terr_o[0]),
      .par_err_cnt(pc0), .stp_err_cnt(sc0), .strt_err_cnt(tc0));

   uart_rx_frame_checker #(.DATA_W(5), .CNT_W(8)) u_d5 (
      .clk(clk), .rst(rst), .frame_start(fs[1]), .bit_vld(bv[1]), .sampled_bit(sb[1]),
      .par_en(pe[1]), .par_typ(pt[1]), .cnt_clr(cc[1]), .busy(busy_o[1]), .p_data(pd5),
      .data_vld(dv[1]), .par_err(perr_o[1]), .stp_err(serr_o[1]), .strt_err(terr_o[1]),
      .par_err_cnt(pc1), .stp_err_cnt(sc1), .strt_err_cnt(tc1));

   uart_rx_frame_checker #(.DATA_W(9), .CNT_W(8)) u_d9 (
      .clk(clk), .rst(rst), .frame_start(fs[2]), .bit_vld(bv[2]), .sampled_bit(sb[2]),
      .par_en(pe[2]), .par_typ(pt[2]), .cnt_clr(cc[2]), .busy(busy_o[2]), .p_data(pd9),
      .data_vld(dv[2]), .par_err(perr_o[2]), .stp_err(serr_o[2]), .strt_err(terr_o[2]),
      .par_err_cnt(pc2), .stp_err_cnt(sc2), .strt_err_cnt(tc2));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] get_pd(input int k);
      logic [31:0] r;
      case (k)
         0:       r = {24'b0, pd8};
         1:       r = {27'b0, pd5};
         default: r = {23'b0, pd9};
      endcase
      return r;
   endfunction

   function automatic logic [31:0] get_cnt(input int k, input int w);
      logic [31:0] r;
      case (k)
         0:       r = (w == 0) ? {30'b0, pc0} : (w == 1) ? {30'b0, sc0} : {30'b0, tc0};
         1:       r = (w == 0) ? {24'b0, pc1} : (w == 1) ? {24'b0, sc1} : {24'b0, tc1};
         default: r = (w == 0) ? {24'b0, pc2} : (w == 1) ? {24'b0, sc2} : {24'b0, tc2};
      endcase
      return r;
   endfunction

   function automatic int sat_inc(input int v, input int k);
      return (v + 1 > cnt_max[k]) ? cnt_max[k] : v + 1;
   endfunction

   task automatic check_state(input int k, input string tag);
      check({tag, "_p_data"}, get_pd(k), {23'b0, exp_pd[k]});
      check({tag, "_par_err"}, perr_o[k], exp_pe[k]);
      check({tag, "_stp_err"}, serr_o[k], exp_se[k]);
      check({tag, "_par_cnt"}, get_cnt(k, 0), exp_pc[k]);
      check({tag, "_stp_cnt"}, get_cnt(k, 1), exp_sc[k]);
      check({tag, "_strt_cnt"}, get_cnt(k, 2), exp_tc[k]);
   endtask

   task automatic gap();
      repeat ($urandom_range(0, 2)) @(negedge clk);
   endtask

   // one strobed bit; a stray frame_start rides along to prove it is ignored while busy
   task automatic send_bit(input int k, input logic b);
      bv[k] = 1'b1;
      sb[k] = b;
      fs[k] = ($urandom_range(0, 3) == 0);
      @(negedge clk);
      bv[k] = 1'b0;
      fs[k] = 1'b0;
      sb[k] = 1'($urandom);
      gap();
   endtask

   task automatic run_frame(input int k, input logic [8:0] data, input logic pen,
                            input logic [1:0] ptyp, input logic pbit, input logic stopb,
                            input logic startb, input logic clr, input logic b2b);
      int         n;
      int         ones;
      logic       expbit;
      logic [8:0] mask;
      n = width[k];
      if (!pre_started) begin
         fs[k] = 1'b1;
         pe[k] = pen;
         pt[k] = ptyp;
         @(negedge clk);
         fs[k] = 1'b0;
      end
      pre_started = 1'b0;
      check("busy_after_start", busy_o[k], 1);
      pe[k] = 1'($urandom);
      pt[k] = 2'($urandom);
      gap();
      if (startb) begin
         bv[k] = 1'b1;
         sb[k] = 1'b1;
         @(negedge clk);
         bv[k] = 1'b0;
         exp_tc[k] = sat_inc(exp_tc[k], k);
         check("strt_err_pulse", terr_o[k], 1);
         check("strt_busy", busy_o[k], 0);
         check("strt_no_vld", dv[k], 0);
         check("strt_cnt", get_cnt(k, 2), exp_tc[k]);
         @(negedge clk);
         check("strt_err_end", terr_o[k], 0);
         return;
      end
      send_bit(k, 1'b0);
      for (int i = 0; i < n; i++) send_bit(k, data[i]);
      if (pen) send_bit(k, pbit);
      ones = 0;
      for (int i = 0; i < n; i++) ones += int'(data[i]);
      case (ptyp)
         2'b00:   expbit = 1'(ones % 2);
         2'b01:   expbit = 1'((ones + 1) % 2);
         2'b10:   expbit = 1'b1;
         default: expbit = 1'b0;
      endcase
      fs[k] = 1'b0;
      bv[k] = 1'b1;
      sb[k] = stopb;
      cc[k] = clr;
      @(negedge clk);
      bv[k] = 1'b0;
      cc[k] = 1'b0;
      mask = 9'((1 << n) - 1);
      exp_pd[k] = data & mask;
      exp_pe[k] = pen && (pbit != expbit);
      exp_se[k] = !stopb;
      if (clr) begin
         exp_pc[k] = 0;
         exp_sc[k] = 0;
         exp_tc[k] = 0;
      end else begin
         if (exp_pe[k]) exp_pc[k] = sat_inc(exp_pc[k], k);
         if (exp_se[k]) exp_sc[k] = sat_inc(exp_sc[k], k);
      end
      check("data_vld_pulse", dv[k], 1);
      check("busy_at_vld", busy_o[k], 0);
      check_state(k, "vld");
      if (b2b) begin
         fs[k] = 1'b1;
         pe[k] = pen;
         pt[k] = ptyp;
         pre_started = 1'b1;
      end
      @(negedge clk);
      fs[k] = 1'b0;
      check("data_vld_end", dv[k], 0);
      check("busy_b2b", busy_o[k], b2b);
      check_state(k, "hold");
   endtask

   initial begin
      int         k;
      logic       r_pen;
      logic [1:0] r_pt;
      logic       startb;
      checks = 0;
      errors = 0;
      pre_started = 1'b0;
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         fs[i] = 0; bv[i] = 0; sb[i] = 1; pe[i] = 0; cc[i] = 0; pt[i] = 2'b00;
         exp_pc[i] = 0; exp_sc[i] = 0; exp_tc[i] = 0;
         exp_pd[i] = '0; exp_pe[i] = 0; exp_se[i] = 0;
      end
      repeat (3) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         check("reset_busy", busy_o[i], 0);
         check("reset_vld", dv[i], 0);
         check("reset_strt_err", terr_o[i], 0);
         check_state(i, "reset");
      end
      rst = 1'b1;
      @(negedge clk);

      // parity types on 0xA5 (four ones)
      run_frame(0, 9'h0A5, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      run_frame(0, 9'h0A5, 1'b1, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      run_frame(0, 9'h0A5, 1'b1, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      run_frame(0, 9'h0A5, 1'b1, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      // no parity, bad stop
      run_frame(0, 9'h03C, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      // start glitch then a clean frame
      run_frame(0, 9'h000, 1'b1, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      run_frame(0, 9'h05A, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

      // asynchronous reset after four data bits
      fs[0] = 1'b1; pe[0] = 1'b1; pt[0] = 2'b00;
      @(negedge clk);
      fs[0] = 1'b0;
      send_bit(0, 1'b0);
      for (int i = 0; i < 4; i++) send_bit(0, 1'($urandom));
      #1 rst = 1'b0;
      #1;
      for (int i = 0; i < 3; i++) begin
         exp_pc[i] = 0; exp_sc[i] = 0; exp_tc[i] = 0;
         exp_pd[i] = '0; exp_pe[i] = 0; exp_se[i] = 0;
      end
      check("midrst_busy", busy_o[0], 0);
      check("midrst_vld", dv[0], 0);
      check_state(0, "midrst");
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 6; i++) begin
         bv[0] = 1'b1; sb[0] = 1'b1;
         @(negedge clk);
         bv[0] = 1'b0;
         check("postrst_no_vld", dv[0], 0);
         check("postrst_idle", busy_o[0], 0);
      end

      // saturation on the 2-bit counters, then clear racing an increment
      for (int i = 0; i < 5; i++)
         run_frame(0, 9'h0A5, 1'b1, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      run_frame(0, 9'h0A5, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

      // narrow and wide builds
      run_frame(1, 9'h015, 1'b1, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      run_frame(2, 9'h1FF, 1'b1, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

      // randomized frames across all three builds
      k = 0; r_pen = 1'b0; r_pt = 2'b00;
      for (int f = 0; f < 60; f++) begin
         if (!pre_started) begin
            k = $urandom_range(0, 2);
            r_pen = 1'($urandom);
            r_pt = 2'($urandom);
         end
         startb = ($urandom_range(0, 7) == 0);
         run_frame(k, 9'($urandom), r_pen, r_pt, 1'($urandom),
                   ($urandom_range(0, 3) != 0), startb,
                   ($urandom_range(0, 15) == 0),
                   !startb && ($urandom_range(0, 3) == 0));
      end

      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
